conv2d_stream_square_kernel: RTL and testbench

CONV2D_STREAM_SQUARE_KERNEL -- requirements
Module: conv2d_stream_square_kernel

---
 rtl/conv2d_stream_square_kernel.sv | 203 ++++++++++++++++++++
 tb/tb_conv2d_stream_square_kernel.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream_square_kernel.sv
// Streaming 2-D convolution with a square KxK kernel, optional stride 2,
// programmable taps and bias, and a saturated single-entry output register.
module conv2d_stream_square_kernel #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     w_we,
    input  logic [$clog2(K*K+1)-1:0] w_addr,
    input  logic [OUT_W-1:0]         w_data,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic [DATA_W-1:0]        input_data,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [OUT_W-1:0]         output_data,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned AW     = $clog2(K*K+1);
    localparam int unsigned NT     = K * K;
    localparam int unsigned CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned LB_N   = (K > 1) ? K - 1 : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;
    // Headroom covers up to 25 products plus the bias without wrapping.
    localparam int unsigned ACC_W  = ((PROD_W > OUT_W) ? PROD_W : OUT_W) + 6;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                    state_q, state_d;
    logic [CW-1:0]             col_q, col_d;
    logic [RW-1:0]             row_q, row_d;
    logic                      vo_q, vo_d;
    logic [OUT_W-1:0]          od_q, od_d;
    logic                      done_q, done_d;
    logic signed [DATA_W-1:0]  w_q [NT];
    logic signed [DATA_W-1:0]  w_d [NT];
    logic signed [OUT_W-1:0]   bias_q, bias_d;

    // Line buffers: lb_mem[0] holds the previous row, lb_mem[K-2] the oldest.
    logic signed [DATA_W-1:0]  lb_mem [LB_N][IMG_W];
    // Window taps, row-major; column K-1 is the most recent column.
    logic signed [DATA_W-1:0]  win_q [NT];
    logic signed [DATA_W-1:0]  win_d [NT];

    logic                      accept;
    logic                      hit;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc;
    logic [OUT_W-1:0]          sat;
    int unsigned               r_u, c_u;

    assign accept      = valid_in && ready_in;
    assign ready_in    = (state_q == StRun) && (!vo_q || ready_out);
    assign busy        = (state_q != StIdle);
    assign valid_out   = vo_q;
    assign output_data = od_q;
    assign done        = done_q;

    // Window shift: new column comes from the line buffers plus the incoming pixel.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    if (j < K - 1) begin
                        win_d[i*K+j] = win_q[i*K+j+1];
                    end else if (i == K - 1) begin
                        win_d[i*K+j] = input_data;
                    end else begin
                        win_d[i*K+j] = lb_mem[K-2-i][col_q];
                    end
                end
            end
        end
    end

    // Window-completion test, full-precision MAC and saturation.
    always_comb begin
        r_u  = int'(row_q);
        c_u  = int'(col_q);
        hit  = (r_u >= K - 1) && (c_u >= K - 1) &&
               (((r_u - (K - 1)) % STRIDE) == 0) && (((c_u - (K - 1)) % STRIDE) == 0);
        prod = '0;
        acc  = {{(ACC_W-OUT_W){bias_q[OUT_W-1]}}, bias_q};
        for (int t = 0; t < NT; t++) begin
            prod = w_q[t] * win_d[t];
            acc  = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
        if ((&acc[ACC_W-1:OUT_W-1]) || (~|acc[ACC_W-1:OUT_W-1])) begin
            sat = acc[OUT_W-1:0];
        end else if (acc[ACC_W-1]) begin
            sat = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // Next state: FSM, raster counters, output register and coefficient writes.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        vo_d    = vo_q;
        od_d    = od_q;
        done_d  = 1'b0;
        w_d     = w_q;
        bias_d  = bias_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    col_d   = '0;
                    row_d   = '0;
                end
                if (w_we) begin
                    if (w_addr < AW'(NT)) begin
                        w_d[w_addr] = w_data[DATA_W-1:0];
                    end else if (w_addr == AW'(NT)) begin
                        bias_d = w_data;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(IMG_H - 1)) begin
                            row_d   = '0;
                            state_d = StDrain;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StDrain: begin
                if (!vo_q || ready_out) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (vo_q && ready_out) begin
            vo_d = 1'b0;
        end
        // Loading is safe: accept implies the register is empty or draining now.
        if (accept && hit) begin
            vo_d = 1'b1;
            od_d = sat;
        end
    end

    // Control and coefficient state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            vo_q    <= 1'b0;
            od_q    <= '0;
            done_q  <= 1'b0;
            bias_q  <= '0;
            for (int t = 0; t < NT; t++) begin
                w_q[t] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            vo_q    <= vo_d;
            od_q    <= od_d;
            done_q  <= done_d;
            bias_q  <= bias_d;
            w_q     <= w_d;
        end
    end

    // Pixel history; never cleared since stale data never reaches a valid window.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (accept) begin
            for (int i = 1; i < LB_N; i++) begin
                lb_mem[i][col_q] <= lb_mem[i-1][col_q];
            end
            lb_mem[0][col_q] <= input_data;
        end
    end

endmodule

// File: tb/tb_conv2d_stream_square_kernel.sv
// Scoreboard bench: instance 0 is 5x4 stride 1, instance 1 is 6x6 stride 2, both K=3.
module tb_conv2d_stream_square_kernel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v       [2];
    logic        w_we_v        [2];
    logic [3:0]  w_addr_v      [2];
    logic [15:0] w_data_v      [2];
    logic        valid_in_v    [2];
    logic        ready_in_v    [2];
    logic [7:0]  input_data_v  [2];
    logic        valid_out_v   [2];
    logic        ready_out_v   [2];
    logic [15:0] output_data_v [2];
    logic        busy_v        [2];
    logic        done_v        [2];

    int checks   = 0;
    int failures = 0;
    int exp_q0[$];
    int exp_q1[$];
    int mw [2][9];
    int mbias [2];
    int img [64];
    int rdy_mode [2];
    int done_cnt [2];
    int stall_cnt [2];
    bit held [2];
    int held_data [2];

    always #5 clk = ~clk;

    conv2d_stream_square_kernel #(
        .DATA_W(8), .IMG_W(5), .IMG_H(4), .K(3), .STRIDE(1), .OUT_W(16)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .w_we(w_we_v[0]), .w_addr(w_addr_v[0]),
        .w_data(w_data_v[0]), .valid_in(valid_in_v[0]), .ready_in(ready_in_v[0]),
        .input_data(input_data_v[0]), .valid_out(valid_out_v[0]), .ready_out(ready_out_v[0]),
        .output_data(output_data_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    conv2d_stream_square_kernel #(
        .DATA_W(8), .IMG_W(6), .IMG_H(6), .K(3), .STRIDE(2), .OUT_W(16)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .w_we(w_we_v[1]), .w_addr(w_addr_v[1]),
        .w_data(w_data_v[1]), .valid_in(valid_in_v[1]), .ready_in(ready_in_v[1]),
        .input_data(input_data_v[1]), .valid_out(valid_out_v[1]), .ready_out(ready_out_v[1]),
        .output_data(output_data_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    function automatic void check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void push_exp(input int i, input int v);
        if (i == 0) exp_q0.push_back(v);
        else exp_q1.push_back(v);
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Reference: direct evaluation of the convolution definition over the stored frame.
    function automatic void model_frame(input int i, input int wd, input int ht, input int s);
        int acc;
        for (int r = 0; r < ht; r++) begin
            for (int c = 0; c < wd; c++) begin
                if (r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0) begin
                    acc = mbias[i];
                    for (int a = 0; a < 3; a++)
                        for (int b = 0; b < 3; b++)
                            acc += mw[i][a*3+b] * img[(r-2+a)*wd + (c-2+b)];
                    if (acc > 32767) acc = 32767;
                    else if (acc < -32768) acc = -32768;
                    push_exp(i, acc);
                end
            end
        end
    endfunction

    function automatic void mon_one(input int i);
        int got;
        int exp;
        got = int'($signed(output_data_v[i]));
        if (done_v[i]) done_cnt[i]++;
        if (valid_out_v[i]) begin
            if (held[i]) check(got == held_data[i], $sformatf("hold_data[%0d]", i), got, held_data[i]);
            if (!ready_out_v[i]) begin
                check(ready_in_v[i] == 1'b0, $sformatf("ready_in_bp[%0d]", i), int'(ready_in_v[i]), 0);
                held[i] = 1'b1;
                held_data[i] = got;
                stall_cnt[i]++;
            end else begin
                held[i] = 1'b0;
                if (qsize(i) == 0) begin
                    check(1'b0, $sformatf("unexpected_result[%0d]", i), got, 0);
                end else begin
                    exp = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check(got == exp, $sformatf("result[%0d]", i), got, exp);
                end
            end
        end else begin
            if (held[i]) check(1'b0, $sformatf("valid_dropped[%0d]", i), 0, 1);
            held[i] = 1'b0;
        end
    endfunction

    // Monitor: decoupled from stimulus, compares every output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held[0] = 1'b0;
                held[1] = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) mon_one(i);
            end
        end
    end

    // Result-side ready: random, forced low, or forced high per instance.
    initial begin
        ready_out_v[0] = 1'b1;
        ready_out_v[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                case (rdy_mode[i])
                    1: ready_out_v[i] = 1'b0;
                    2: ready_out_v[i] = 1'b1;
                    default: ready_out_v[i] = ($urandom_range(0, 3) != 0);
                endcase
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wr(input int i, input int addr, input int data);
        w_we_v[i] = 1'b1;
        w_addr_v[i] = 4'(addr);
        w_data_v[i] = 16'(data);
        @(posedge clk);
        #1;
        w_we_v[i] = 1'b0;
        if (addr < 9) mw[i][addr] = int'($signed(w_data_v[i][7:0]));
        else if (addr == 9) mbias[i] = int'($signed(w_data_v[i]));
    endtask

    task automatic load_random(input int i);
        for (int a = 0; a < 10; a++) wr(i, a, int'($urandom));
        repeat (2) wr(i, int'($urandom_range(10, 15)), int'($urandom));
    endtask

    task automatic load_const(input int i, input int tap, input int bias);
        for (int a = 0; a < 9; a++) wr(i, a, tap);
        wr(i, 9, bias);
    endtask

    task automatic random_img(input int n);
        logic [7:0] b;
        for (int p = 0; p < n; p++) begin
            b = 8'($urandom);
            img[p] = int'($signed(b));
        end
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check(busy_v[i] == 1'b0, $sformatf("rst_busy[%0d]", i), int'(busy_v[i]), 0);
            check(done_v[i] == 1'b0, $sformatf("rst_done[%0d]", i), int'(done_v[i]), 0);
            check(valid_out_v[i] == 1'b0, $sformatf("rst_valid_out[%0d]", i), int'(valid_out_v[i]), 0);
            check(ready_in_v[i] == 1'b0, $sformatf("rst_ready_in[%0d]", i), int'(ready_in_v[i]), 0);
            check(output_data_v[i] == 16'd0, $sformatf("rst_output_data[%0d]", i),
                  int'(output_data_v[i]), 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Drive one frame; optionally intrude with start/w_we, or reset at pixel abort_at.
    task automatic run_frame(input int i, input int npix, input int intrude_at, input int abort_at);
        int  budget;
        bit  acc;
        done_cnt[i] = 0;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        @(negedge clk);
        check(busy_v[i] == 1'b1, $sformatf("busy_after_start[%0d]", i), int'(busy_v[i]), 1);
        @(posedge clk);
        #1;
        for (int p = 0; p < npix; p++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            valid_in_v[i] = 1'b1;
            input_data_v[i] = 8'(img[p]);
            if (p == abort_at) begin
                rst = 1'b1;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                rst = 1'b0;
                valid_in_v[i] = 1'b0;
                return;
            end
            if (p == intrude_at) begin
                w_we_v[i] = 1'b1;
                w_addr_v[i] = 4'd4;
                w_data_v[i] = 16'h0055;
                start_v[i] = 1'b1;
            end
            budget = 0;
            acc = 1'b0;
            while (!acc) begin
                @(negedge clk);
                acc = ready_in_v[i];
                @(posedge clk);
                #1;
                w_we_v[i] = 1'b0;
                start_v[i] = 1'b0;
                budget++;
                if (!acc && budget > 300) begin
                    check(1'b0, $sformatf("pixel_accept_timeout[%0d]", i), p, npix);
                    valid_in_v[i] = 1'b0;
                    return;
                end
            end
            valid_in_v[i] = 1'b0;
        end
    endtask

    task automatic finish_frame(input int i);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_v[i] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(busy_v[i] == 1'b0, $sformatf("frame_end[%0d]", i), int'(busy_v[i]), 0);
        repeat (2) @(negedge clk);
        check(done_cnt[i] == 1, $sformatf("done_count[%0d]", i), done_cnt[i], 1);
        check(qsize(i) == 0, $sformatf("results_missing[%0d]", i), qsize(i), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vo_seen;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            w_we_v[i] = 1'b0;
            w_addr_v[i] = '0;
            w_data_v[i] = '0;
            valid_in_v[i] = 1'b0;
            input_data_v[i] = '0;
            rdy_mode[i] = 0;
            done_cnt[i] = 0;
            stall_cnt[i] = 0;
            held[i] = 1'b0;
            held_data[i] = 0;
            mbias[i] = 0;
            for (int a = 0; a < 9; a++) mw[i][a] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs();

        // Cleared coefficients give zero results.
        random_img(20);
        repeat (6) push_exp(0, 0);
        run_frame(0, 20, -1, -1);
        finish_frame(0);

        // Uniform frame: 6 results of 9.
        load_const(0, 1, 0);
        for (int p = 0; p < 20; p++) img[p] = 1;
        repeat (6) push_exp(0, 9);
        run_frame(0, 20, -1, -1);
        finish_frame(0);

        // Centre tap only, pixel = raster index.
        load_const(0, 0, 0);
        wr(0, 4, 1);
        for (int p = 0; p < 20; p++) img[p] = p;
        push_exp(0, 6); push_exp(0, 7); push_exp(0, 8);
        push_exp(0, 11); push_exp(0, 12); push_exp(0, 13);
        run_frame(0, 20, -1, -1);
        finish_frame(0);

        // Random frames; the second reuses coefficients from the first.
        for (int f = 0; f < 4; f++) begin
            if (f != 1) load_random(0);
            random_img(20);
            model_frame(0, 5, 4, 1);
            run_frame(0, 20, -1, -1);
            finish_frame(0);
        end

        // Backpressure: hold ready_out low for 10 cycles once a result is waiting.
        load_random(0);
        random_img(20);
        model_frame(0, 5, 4, 1);
        stall_cnt[0] = 0;
        fork
            run_frame(0, 20, -1, -1);
            begin
                int n;
                n = 0;
                while (!valid_out_v[0] && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                rdy_mode[0] = 1;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                end
                rdy_mode[0] = 0;
            end
        join
        finish_frame(0);
        check(stall_cnt[0] >= 9, "bp_stall_cycles", stall_cnt[0], 9);

        // Illegal write and start while running are dropped.
        random_img(20);
        model_frame(0, 5, 4, 1);
        run_frame(0, 20, 5, -1);
        finish_frame(0);

        // Reset at pixel 7 aborts the frame and clears coefficients.
        random_img(20);
        run_frame(0, 20, -1, 7);
        for (int a = 0; a < 9; a++) mw[0][a] = 0;
        mbias[0] = 0;
        done_cnt[0] = 0;
        check_reset_outputs();
        vo_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid_out_v[0]) vo_seen++;
        end
        check(vo_seen == 0, "abort_no_valid", vo_seen, 0);
        check(done_cnt[0] == 0, "abort_no_done", done_cnt[0], 0);
        @(posedge clk);
        #1;
        random_img(20);
        model_frame(0, 5, 4, 1);
        run_frame(0, 20, -1, -1);
        finish_frame(0);
        load_random(0);
        random_img(20);
        model_frame(0, 5, 4, 1);
        run_frame(0, 20, -1, -1);
        finish_frame(0);

        // Stride 2 on a 6x6 image.
        for (int f = 0; f < 2; f++) begin
            load_random(1);
            random_img(36);
            model_frame(1, 6, 6, 2);
            run_frame(1, 36, -1, -1);
            finish_frame(1);
        end

        // Positive saturation: raw 145161 clamps to 32767.
        load_const(1, 127, 0);
        for (int p = 0; p < 36; p++) img[p] = 127;
        repeat (4) push_exp(1, 32767);
        run_frame(1, 36, -1, -1);
        finish_frame(1);

        // Negative saturation: raw -146304 clamps to -32768.
        for (int p = 0; p < 36; p++) img[p] = -128;
        repeat (4) push_exp(1, -32768);
        run_frame(1, 36, -1, -1);
        finish_frame(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
